// File: rtl/bcd2bin_n.sv
// bcd2bin_n: iterative packed-BCD to binary converter (reverse double dabble).
// Define BCD2BIN_N_ERR_EN to reject operands that contain a nibble above 9.
module bcd2bin_n #(
    parameter int NDIG  = 5,
    parameter int OUT_W = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic [4*NDIG-1:0]  A,
    output logic [OUT_W-1:0]   result,
    output logic               done,
    output logic               busy,
    output logic               ovf,
    output logic               err
);

    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [2*W-1:0]  sreg;
    logic [2*W-1:0]  itr;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            bad;
    logic            ovf_n;
    logic            err_q;

    // Upper half is the BCD field, lower half collects the binary value.
    always_comb begin
        itr = sreg >> 1;
        for (int i = 0; i < NDIG; i++) begin
            if (itr[W+4*i +: 4] >= 4'd8) begin
                itr[W+4*i +: 4] = itr[W+4*i +: 4] - 4'd3;
            end
        end
    end

    assign last = (cnt == CW'(1));

    generate
        if (OUT_W < W) begin : g_ovf
            assign ovf_n = |itr[W-1:OUT_W];
        end else begin : g_no_ovf
            assign ovf_n = 1'b0;
        end
    endgenerate

`ifdef BCD2BIN_N_ERR_EN
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (A[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
    end
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (init) state_n = bad ? DONE : CONV;
            CONV:    if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            result <= '0;
            ovf    <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (init) begin
                        sreg <= {A, {W{1'b0}}};
                        cnt  <= CW'(W);
                        // Invalid operand skips conversion entirely.
                        if (bad) begin
                            result <= '0;
                            ovf    <= 1'b0;
                            err_q  <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    sreg <= itr;
                    cnt  <= cnt - CW'(1);
                    if (last) begin
                        result <= itr[OUT_W-1:0];
                        ovf    <= ovf_n;
                        err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = (state == DONE);
    assign busy = (state != IDLE);
    assign err  = err_q;

endmodule
